// File: rtl/uc_pkg.sv
// Shared definitions for the microc sequencing control unit: opcodes, FSM
// states and the datapath control word.
package uc_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_JZ  = 6'b000010;
    localparam logic [5:0] OP_JNZ = 6'b000011;
    localparam logic [3:0] OP_LI  = 4'b0001;
    localparam logic [2:0] OP_ALU = 3'b001;
    localparam logic [5:0] OP_HLT = 6'b111111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_WAIT = 2'b10,
        ST_HALT      = 2'b11
    } uc_state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } uc_ctrl_t;

    // Control word that leaves the datapath untouched: advance nothing, write nothing.
    function automatic uc_ctrl_t ctrl_idle();
        uc_ctrl_t c;
        c.s_inc = 1'b1;
        c.s_inm = 1'b0;
        c.we3   = 1'b0;
        c.wez   = 1'b0;
        c.op    = 3'b000;
        return c;
    endfunction

endpackage

// File: rtl/uc_dec.sv
// Pure combinational opcode decoder: opcode and zero flag to the raw
// control word, plus a flag telling whether the opcode is defined.
module uc_dec
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output uc_ctrl_t   ctrl,
    output logic       legal
);

    // Raw control word per opcode; undefined opcodes fall back to a nop word.
    always_comb begin
        ctrl  = ctrl_idle();
        legal = 1'b1;
        casez (opcode)
            OP_NOP: begin
                ctrl.s_inc = 1'b1;
            end
            OP_J: begin
                ctrl.s_inc = 1'b0;
            end
            OP_JZ: begin
                ctrl.s_inc = ~z;
            end
            OP_JNZ: begin
                ctrl.s_inc = z;
            end
            {OP_LI, 2'b??}: begin
                ctrl.we3   = 1'b1;
                ctrl.s_inm = 1'b1;
            end
            {OP_ALU, 3'b???}: begin
                ctrl.we3 = 1'b1;
                ctrl.wez = 1'b1;
                ctrl.op  = opcode[2:0];
            end
            OP_HLT: begin
                ctrl.s_inc = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit for microc: run/step/halt FSM that gates the
// decoded control word, plus executed-instruction counter and sticky illegal flag.
module uc_seq
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        z,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  op,
    output logic        pc_en,
    output logic [1:0]  state,
    output logic [15:0] instr_cnt,
    output logic        halted,
    output logic        illegal
);

    uc_state_t   r_state;
    uc_state_t   w_state_nxt;
    logic [15:0] r_instr_cnt;
    logic        r_illegal;

    uc_ctrl_t    w_raw;
    uc_ctrl_t    w_ctrl;
    logic        w_legal;
    logic        w_exec;
    logic        w_hlt;

    uc_dec u_dec (
        .opcode (opcode),
        .z      (z),
        .ctrl   (w_raw),
        .legal  (w_legal)
    );

    assign w_hlt  = (opcode == OP_HLT);
    assign w_exec = (r_state == ST_RUN) || ((r_state == ST_STEP_WAIT) && step);

    // Gate the raw control word: only execute cycles may touch the datapath.
    always_comb begin
        w_ctrl = ctrl_idle();
        pc_en  = 1'b0;
        if (w_exec && !w_hlt) begin
            w_ctrl = w_raw;
            pc_en  = 1'b1;
        end else begin
            w_ctrl = ctrl_idle();
            pc_en  = 1'b0;
        end
    end

    assign s_inc     = w_ctrl.s_inc;
    assign s_inm     = w_ctrl.s_inm;
    assign we3       = w_ctrl.we3;
    assign wez       = w_ctrl.wez;
    assign op        = w_ctrl.op;
    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;
    assign halted    = (r_state == ST_HALT);
    assign illegal   = r_illegal;

    // Next-state logic; HALT is left only through reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = step_mode ? ST_STEP_WAIT : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_hlt) begin
                    w_state_nxt = ST_HALT;
                end else if (step_mode) begin
                    w_state_nxt = ST_STEP_WAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                if (step && w_hlt) begin
                    w_state_nxt = ST_HALT;
                end else if (!step_mode) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_STEP_WAIT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating count of executed non-halt instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_cnt <= 16'h0000;
        end else if (w_exec && !w_hlt && (r_instr_cnt != CNT_MAX)) begin
            r_instr_cnt <= r_instr_cnt + 16'h0001;
        end
    end

    // Sticky flag for an undefined opcode reaching an execute cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (w_exec && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

endmodule
